// File: rtl/bpsk_tx_scheduler.sv
// BPSK transmit sequencer: word FIFO, LSB-first bit serializer
// and sine-table phase counter, one bit per full sine period.
module bpsk_tx_scheduler #(
  parameter int SAMPLE_NUMBER = 256,
  parameter int SAMPLE_WIDTH  = 12,
  parameter int DATA_WIDTH    = 12,
  parameter int FIFO_DEPTH    = 4
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             sample_en,
  input  logic                             flush,
  input  logic [DATA_WIDTH-1:0]            s_data,
  input  logic                             s_valid,
  output logic                             s_ready,
  output logic [$clog2(SAMPLE_NUMBER)-1:0] lut_addr,
  output logic                             bit_out,
  output logic                             mod_en,
  output logic                             busy,
  output logic                             word_done,
  output logic [$clog2(FIFO_DEPTH):0]      fifo_level
);

  localparam int PW = $clog2(SAMPLE_NUMBER);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  if (SAMPLE_WIDTH < 1 || DATA_WIDTH < 2 ||
      SAMPLE_NUMBER < 2 ||
      (SAMPLE_NUMBER & (SAMPLE_NUMBER - 1)) != 0 ||
      FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_param
    $error("bpsk_tx_scheduler: illegal parameters");
  end

  typedef enum logic {
    IDLE,
    SEND
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [LW-1:0]         count;
  logic [DATA_WIDTH-1:0] sr;
  logic [BW-1:0]         bit_idx;
  logic [PW-1:0]         phase;

  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic                  bit_end;
  logic                  word_end;
  logic [DATA_WIDTH-1:0] head;

  assign full  = (count == LW'(FIFO_DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  // ready is masked during reset so nothing is accepted then
  assign s_ready = !rst && !full;
  assign push    = s_valid && s_ready && !flush;

  assign bit_end  = (state == SEND) && sample_en &&
                    (phase == PW'(SAMPLE_NUMBER - 1));
  assign word_end = bit_end &&
                    (bit_idx == BW'(DATA_WIDTH - 1));
  assign pop      = !flush && !empty &&
                    ((state == IDLE) || word_end);

  assign busy       = (state == SEND);
  assign mod_en     = (state == SEND) && sample_en;
  assign lut_addr   = phase;
  assign fifo_level = count;

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= s_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      state     <= IDLE;
      sr        <= '0;
      bit_idx   <= '0;
      phase     <= '0;
      bit_out   <= 1'b0;
      word_done <= 1'b0;
    end else begin
      word_done <= word_end;
      unique case (state)
        IDLE: begin
          if (!empty) begin
            state   <= SEND;
            sr      <= head;
            bit_out <= head[0];
            bit_idx <= '0;
            phase   <= '0;
          end
        end
        SEND: begin
          if (sample_en) begin
            phase <= phase + 1'b1;
            if (bit_end && !word_end) begin
              bit_idx <= bit_idx + 1'b1;
              sr      <= sr >> 1;
              bit_out <= sr[1];
            end else if (word_end) begin
              bit_idx <= '0;
              // next word starts on the very next sample
              if (!empty) begin
                sr      <= head;
                bit_out <= head[0];
              end else begin
                state   <= IDLE;
                bit_out <= 1'b0;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bpsk_tx_scheduler.sv
// Randomized bench for bpsk_tx_scheduler against a
// word/sample-count reference model.
module tb_bpsk_tx_scheduler;

  localparam int SN = 4;
  localparam int DW = 4;
  localparam int FD = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_en = 1'b0;
  logic          flush = 1'b0;
  logic          s_valid = 1'b0;
  logic [DW-1:0] s_data = '0;
  logic          s_ready;
  logic [1:0]    lut_addr;
  logic          bit_out;
  logic          mod_en;
  logic          busy;
  logic          word_done;
  logic [1:0]    fifo_level;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  logic [DW-1:0] q[$];
  bit            act = 0;
  logic [DW-1:0] cur = '0;
  int            k = 0;
  bit            done = 0;

  bpsk_tx_scheduler #(
    .SAMPLE_NUMBER(SN),
    .SAMPLE_WIDTH (12),
    .DATA_WIDTH   (DW),
    .FIFO_DEPTH   (FD)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .sample_en (sample_en),
    .flush     (flush),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .lut_addr  (lut_addr),
    .bit_out   (bit_out),
    .mod_en    (mod_en),
    .busy      (busy),
    .word_done (word_done),
    .fifo_level(fifo_level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h",
               tag, cyc, got, exp);
    end
  endtask

  task automatic step(input bit r, input bit f,
                      input bit se, input bit v,
                      input logic [DW-1:0] d);
    bit full_now;
    bit nd;
    @(negedge clk);
    rst = r;
    flush = f;
    sample_en = se;
    s_valid = v;
    s_data = d;
    #1;
    check("s_ready", 32'(s_ready),
          32'(!r && q.size() < FD));
    check("level", 32'(fifo_level), 32'(q.size()));
    check("busy", 32'(busy), 32'(act));
    check("lut_addr", 32'(lut_addr),
          32'(act ? k % SN : 0));
    check("bit_out", 32'(bit_out),
          32'(act ? cur[k / SN] : 1'b0));
    check("mod_en", 32'(mod_en), 32'(act && se));
    check("word_done", 32'(word_done), 32'(done));
    cyc++;
    if (r || f) begin
      q.delete();
      act = 0;
      k = 0;
      done = 0;
    end else begin
      full_now = (q.size() >= FD);
      nd = 0;
      if (!act) begin
        if (q.size() > 0) begin
          cur = q.pop_front();
          act = 1;
          k = 0;
        end
      end else if (se) begin
        if (k == SN * DW - 1) begin
          nd = 1;
          k = 0;
          if (q.size() > 0) cur = q.pop_front();
          else act = 0;
        end else begin
          k++;
        end
      end
      if (v && !full_now) q.push_back(d);
      done = nd;
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    step(1, 0, 1, 0, '0);
    step(1, 0, 1, 1, 4'hF);
    // single word
    step(0, 0, 1, 1, 4'b1011);
    repeat (22) step(0, 0, 1, 0, '0);
    // back-to-back words
    step(0, 0, 1, 1, 4'hA);
    step(0, 0, 1, 1, 4'h5);
    repeat (40) step(0, 0, 1, 0, '0);
    // fill the FIFO behind an active word
    step(0, 0, 1, 1, 4'h3);
    repeat (3) step(0, 0, 1, 1, 4'hC);
    repeat (20) step(0, 0, 1, 1, 4'h6);
    repeat (60) step(0, 0, 1, 0, '0);
    // flush mid-word with a buffered word and a push
    step(0, 0, 1, 1, 4'h9);
    step(0, 0, 1, 1, 4'h7);
    repeat (8) step(0, 0, 1, 0, '0);
    step(0, 1, 1, 1, 4'hE);
    repeat (4) step(0, 0, 1, 0, '0);
    // reset mid-word, then normal traffic
    step(0, 0, 1, 1, 4'hD);
    repeat (6) step(0, 0, 1, 0, '0);
    step(1, 0, 1, 1, 4'h2);
    step(0, 0, 1, 1, 4'h2);
    repeat (20) step(0, 0, 1, 0, '0);
    // random traffic, full rate
    for (int i = 0; i < 1500; i++)
      step(0, 0, 1, $urandom_range(0, 3) == 0,
           DW'($urandom));
    // random traffic, every third cycle strobed
    for (int i = 0; i < 1500; i++)
      step(0, 0, (i % 3) == 0,
           $urandom_range(0, 5) == 0, DW'($urandom));
    // random strobe, flush and reset
    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 149) == 0,
           $urandom_range(0, 63) == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 3) == 0, DW'($urandom));
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule

// File: doc/bpsk_tx_scheduler.md
# bpsk_tx_scheduler

Transmit-side sequencer for the BPSK path. It accepts data words over a valid/ready stream and buffers them in a small FIFO. Each word is serialized LSB-first, one bit per full sine period. The block drives the sine-table phase address, the per-sample modulator enable and the current symbol bit that the BPSK modulator and sine/negated-sine tables consume. It replaces ad-hoc counter and data-latch logic in the transmitter top level with one controller that owns symbol timing and back-to-back word scheduling.

## Interface
- SAMPLE_NUMBER, 256: samples per sine period, which is also samples per bit. Must be a power of two and ≥ 2.
- SAMPLE_WIDTH, 12: width of the sine samples. Not used internally; carried for top-level consistency.
- DATA_WIDTH, 12: bits per data word.
- FIFO_DEPTH, 4: number of word buffer entries. Must be a power of two and ≥ 2.

Ports:
- clk  in  1  single clock; all logic is on its rising edge.
- rst  in  1  synchronous, active-high reset.
- sample_en  in  1  sample-rate strobe; phase advances only on cycles where it is 1.
- flush  in  1  synchronous abort: empties the FIFO and aborts the current word.
- s_data  in  DATA_WIDTH  word to transmit.
- s_valid  in  1  s_data is valid.
- s_ready  out  1  FIFO can accept a word; equals !full.
- lut_addr  out  $clog2(SAMPLE_NUMBER)  sine-table phase address.
- bit_out  out  1  current symbol bit: 1 selects sine, 0 selects negated sine.
- mod_en  out  1  modulator enable for this sample.
- busy  out  1  a word is being transmitted.
- word_done  out  1  one-cycle pulse after the last sample of a word.
- fifo_level  out  $clog2(FIFO_DEPTH)+1  number of words currently buffered.

## Operation
- FIFO:
  - A push happens when s_valid && s_ready.
  - A pop is internal and happens only on the word loads defined below.
  - A push and a pop in the same cycle leave the level unchanged.
  - When full, s_ready=0 and s_valid is ignored; there is no push-through.
- Internal registers:
  - state ∈ {IDLE, SEND}
  - shift register sr [DATA_WIDTH-1:0]
  - bit index bit_idx, 0..DATA_WIDTH-1
  - phase counter, which drives lut_addr directly
- IDLE:
  - busy=0, mod_en=0, lut_addr=0, bit_idx=0.
  - If the FIFO is non-empty: pop, sr←head, bit_out←head[0], go to SEND.
- SEND:
  - busy=1 and mod_en = sample_en (combinational gate of the registered state).
  - On each cycle with sample_en=1, the phase increments modulo SAMPLE_NUMBER.
  - When the phase is SAMPLE_NUMBER-1 and sample_en=1 (end of a bit):
    - If bit_idx < DATA_WIDTH-1: bit_idx+1, sr shifts right, bit_out←sr[1].
    - If bit_idx = DATA_WIDTH-1 (end of word): word_done pulses next cycle, bit_idx←0, phase←0.
      - FIFO non-empty: pop, load the next word in the same cycle, stay in SEND. There is no gap sample.
      - FIFO empty: go to IDLE, bit_out←0.
- sample_en=0 in SEND: all state holds and mod_en=0.
- flush=1 (priority over push, pop and phase advance):
  - FIFO level←0, state←IDLE, phase←0, bit_idx←0, bit_out←0.
  - word_done is not asserted for the aborted word.
  - A simultaneous push is discarded.
- rst has priority over flush.

## Timing
- Reset values: state IDLE, lut_addr 0, bit_out 0, mod_en 0, busy 0, word_done 0, fifo_level 0, s_ready 0 while rst=1 and 1 in the first cycle after it.
- Start-up latency for a push into an empty, idle block:
  - Push at edge N.
  - fifo_level=1 after N.
  - Pop at edge N+1: busy=1, lut_addr=0, bit_out=word[0].
  - The first mod_en sample is in the cycle after edge N+1, if sample_en=1.
- Word duration: exactly DATA_WIDTH·SAMPLE_NUMBER sample_en strobes.
- Back-to-back words: the phase wraps from SAMPLE_NUMBER-1 to 0 with no idle sample.
- bit_out changes only on the edge where lut_addr wraps to 0, so it is aligned to the phase-0 sample.
- word_done is high for exactly one cycle, in the cycle after the edge that completed the last sample.
- s_ready and fifo_level reflect registered FIFO state only. There is no combinational path from s_valid to s_ready.

## Test plan
Bench parameters unless stated: SAMPLE_NUMBER=4, DATA_WIDTH=4, FIFO_DEPTH=2, sample_en tied to 1.
1. Single word: push 4'b1011 into an idle block.
   - bit_out sequence per 4-sample period: 1,1,0,1.
   - lut_addr cycles 0,1,2,3 four times.
   - mod_en is high for 16 cycles; word_done pulses once; then IDLE with busy=0.
2. Back-to-back: push 4'hA and 4'h5 before the first word ends.
   - 32 consecutive mod_en cycles, bit_out = 0,1,0,1,1,0,1,0.
   - word_done pulses at cycles 16 and 32 relative to the first sample.
3. Full FIFO: with a word in SEND, push 2 more words.
   - s_ready=0 and fifo_level=2.
   - A third push is held off until the next load, which raises s_ready in the cycle after the pop.
4. Throttled rate: sample_en high every 3rd cycle.
   - Word still spans 16 strobes; all outputs hold between strobes; mod_en is high only on strobe cycles.
5. Flush mid-word: assert flush during bit 2 with 1 word buffered.
   - Next cycle: fifo_level=0, busy=0, lut_addr=0, bit_out=0, and no word_done pulse.
   - A push on the flush cycle is lost.
6. Reset mid-word: assert rst during SEND.
   - All outputs take reset values next cycle and s_ready=0 during reset.
   - After release, a new push transmits normally.
